// File: rtl/psr_stack.sv
// Program status register with a LIFO shadow stack.
// Captures ALU flags, loads a flag value directly, and saves/restores the
// flag vector on push/pop for interrupt entry/return and call/ret.
module psr_stack #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_en,
  input  logic [DATA_W-1:0] res,
  input  logic              carry,
  input  logic              ovf,
  input  logic              ld_en,
  input  logic [6:0]        ld_val,
  input  logic              push,
  input  logic              pop,
  output logic [6:0]        program_status,
  output logic [CNT_W-1:0]  depth_cnt,
  output logic              stk_full,
  output logic              stk_empty,
  output logic              stk_err
);

  localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [6:0]       stack [DEPTH];
  logic [6:0]       alu_flags;
  logic [6:0]       psr_nxt;
  logic [CNT_W-1:0] depth_nxt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             is_full;
  logic             is_empty;
  logic             do_push;
  logic             do_pop;
  logic             err_evt;

  // Decode stack legality from the registered depth; conflicting or
  // out-of-range requests are dropped and flagged.
  always_comb begin
    is_full  = (depth_cnt == DEPTH_C);
    is_empty = (depth_cnt == '0);
    do_push  = push & ~pop & ~is_full;
    do_pop   = pop & ~push & ~is_empty;
    err_evt  = (push & pop) | (push & is_full) | (pop & is_empty);
    wr_ptr   = depth_cnt[PTR_W-1:0];
    rd_ptr   = PTR_W'(depth_cnt - ONE_C);
  end

  // Flag vector derived from the ALU result, bit 0 upward:
  // odd parity, even, zero, positive, carry, negative, overflow.
  always_comb begin
    alu_flags = {ovf,
                 res[DATA_W-1],
                 carry,
                 ~res[DATA_W-1] & (|res),
                 ~(|res),
                 ~res[0],
                 ^res};
  end

  // Next PSR and depth: a restoring pop beats a direct load, which beats
  // an ALU capture. A push saves the pre-edge PSR, so it never blocks an
  // update in the same cycle.
  always_comb begin
    psr_nxt   = program_status;
    depth_nxt = depth_cnt;
    if (do_pop) begin
      psr_nxt = stack[rd_ptr];
    end else if (ld_en) begin
      psr_nxt = ld_val;
    end else if (upd_en) begin
      psr_nxt = alu_flags;
    end
    if (do_push) begin
      depth_nxt = depth_cnt + ONE_C;
    end else if (do_pop) begin
      depth_nxt = depth_cnt - ONE_C;
    end
  end

  // Registered PSR, depth, full/empty and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      program_status <= 7'b0000000;
      depth_cnt      <= '0;
      stk_full       <= 1'b0;
      stk_empty      <= 1'b1;
      stk_err        <= 1'b0;
    end else begin
      program_status <= psr_nxt;
      depth_cnt      <= depth_nxt;
      stk_full       <= (depth_nxt == DEPTH_C);
      stk_empty      <= (depth_nxt == '0);
      if (err_evt) begin
        stk_err <= 1'b1;
      end
    end
  end

  // Stack storage has no reset; entries above depth_cnt are never read.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      stack[wr_ptr] <= program_status;
    end
  end

endmodule

// File: tb/tb_psr_stack.sv
// Directed bench for psr_stack: each driven vector queues the expected
// post-edge state; a negedge monitor pops and compares.
module tb_psr_stack;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              upd_en = 1'b0;
  logic [DATA_W-1:0] res = '0;
  logic              carry = 1'b0;
  logic              ovf = 1'b0;
  logic              ld_en = 1'b0;
  logic [6:0]        ld_val = '0;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic [6:0]        program_status;
  logic [CNT_W-1:0]  depth_cnt;
  logic              stk_full;
  logic              stk_empty;
  logic              stk_err;

  psr_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .upd_en(upd_en), .res(res), .carry(carry),
    .ovf(ovf), .ld_en(ld_en), .ld_val(ld_val), .push(push), .pop(pop),
    .program_status(program_status), .depth_cnt(depth_cnt),
    .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        upd;
    logic [31:0] res;
    logic        c;
    logic        o;
    logic        ld;
    logic [6:0]  ldv;
    logic        psh;
    logic        pp;
    logic [6:0]  e_psr;
    int          e_dep;
    logic        e_err;
  } vec_t;

  typedef struct {
    string      name;
    int         tgt;
    logic [6:0] psr;
    int         dep;
    logic       err;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic add(input string nm, input logic r, input logic u,
                     input logic [31:0] rs, input logic c, input logic o,
                     input logic l, input logic [6:0] lv, input logic ps,
                     input logic pp, input logic [6:0] ep, input int ed,
                     input logic ee);
    vec_t v;
    v.name = nm; v.rst = r; v.upd = u; v.res = rs; v.c = c; v.o = o;
    v.ld = l; v.ldv = lv; v.psh = ps; v.pp = pp;
    v.e_psr = ep; v.e_dep = ed; v.e_err = ee;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input string fld, input int act,
                     input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, expv);
    end
  endtask

  // Monitor: compare the expectation whose target edge just occurred.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].tgt <= edge_cnt) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.tgt < edge_cnt) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s.missed: checked at edge %0d required edge %0d",
                 e.name, edge_cnt, e.tgt);
      end else begin
        chk(e.name, "status", int'(program_status), int'(e.psr));
        chk(e.name, "depth",  int'(depth_cnt), e.dep);
        chk(e.name, "full",   int'(stk_full), (e.dep == DEPTH) ? 1 : 0);
        chk(e.name, "empty",  int'(stk_empty), (e.dep == 0) ? 1 : 0);
        chk(e.name, "err",    int'(stk_err), int'(e.err));
      end
    end
  end

  initial begin
    //   name        rst upd res           c  o  ld ldv    psh pop  psr    dep err
    add("reset0",    1, 0, 32'h0,        0, 0, 0, 7'h00, 0, 0,  7'h00, 0, 0);
    add("reset1",    1, 0, 32'h0,        0, 0, 0, 7'h00, 0, 0,  7'h00, 0, 0);
    add("flag_zero", 0, 1, 32'h0,        0, 0, 0, 7'h00, 0, 0,  7'h06, 0, 0);
    add("flag_neg",  0, 1, 32'h80000001, 1, 1, 0, 7'h00, 0, 0,  7'h70, 0, 0);
    add("flag_pos",  0, 1, 32'h3,        0, 0, 0, 7'h00, 0, 0,  7'h08, 0, 0);
    add("ld15",      0, 0, 32'h0,        0, 0, 1, 7'h15, 0, 0,  7'h15, 0, 0);
    add("push15",    0, 0, 32'h0,        0, 0, 0, 7'h00, 1, 0,  7'h15, 1, 0);
    add("ld2a",      0, 0, 32'h0,        0, 0, 1, 7'h2A, 0, 0,  7'h2A, 1, 0);
    add("push2a",    0, 0, 32'h0,        0, 0, 0, 7'h00, 1, 0,  7'h2A, 2, 0);
    add("pop2a",     0, 0, 32'h0,        0, 0, 0, 7'h00, 0, 1,  7'h2A, 1, 0);
    add("pop15",     0, 0, 32'h0,        0, 0, 0, 7'h00, 0, 1,  7'h15, 0, 0);
    add("fill1",     0, 0, 32'h0,        0, 0, 1, 7'h01, 1, 0,  7'h01, 1, 0);
    add("fill2",     0, 0, 32'h0,        0, 0, 1, 7'h02, 1, 0,  7'h02, 2, 0);
    add("fill3",     0, 0, 32'h0,        0, 0, 1, 7'h03, 1, 0,  7'h03, 3, 0);
    add("fill4",     0, 0, 32'h0,        0, 0, 1, 7'h04, 1, 0,  7'h04, 4, 0);
    add("push_full", 0, 0, 32'h0,        0, 0, 1, 7'h05, 1, 0,  7'h05, 4, 1);
    add("lifo3",     0, 0, 32'h0,        0, 0, 0, 7'h00, 0, 1,  7'h03, 3, 1);
    add("pop_vs_ld", 0, 0, 32'h0,        0, 0, 1, 7'h7F, 0, 1,  7'h02, 2, 1);
    add("lifo1",     0, 0, 32'h0,        0, 0, 0, 7'h00, 0, 1,  7'h01, 1, 1);
    add("lifo15",    0, 0, 32'h0,        0, 0, 0, 7'h00, 0, 1,  7'h15, 0, 1);
    add("pop_empty", 0, 1, 32'h0,        0, 0, 0, 7'h00, 0, 1,  7'h06, 0, 1);
    add("reset2",    1, 1, 32'h3,        0, 0, 1, 7'h55, 1, 0,  7'h00, 0, 0);
    add("push_ld11", 0, 0, 32'h0,        0, 0, 1, 7'h11, 1, 0,  7'h11, 1, 0);
    add("push_pop",  0, 0, 32'h0,        0, 0, 0, 7'h00, 1, 1,  7'h11, 1, 1);
    add("reset3",    1, 0, 32'h0,        0, 0, 0, 7'h00, 0, 0,  7'h00, 0, 0);
    add("pushA",     0, 0, 32'h0,        0, 0, 0, 7'h00, 1, 0,  7'h00, 1, 0);
    add("pushB",     0, 0, 32'h0,        0, 0, 0, 7'h00, 1, 0,  7'h00, 2, 0);
    add("pushC",     0, 1, 32'h1,        0, 0, 0, 7'h00, 1, 0,  7'h09, 3, 0);
    add("rst_push",  1, 0, 32'h0,        0, 0, 0, 7'h00, 1, 0,  7'h00, 0, 0);
    add("pop_after", 0, 0, 32'h0,        0, 0, 0, 7'h00, 0, 1,  7'h00, 0, 1);
    add("hold",      0, 0, 32'h0,        0, 0, 0, 7'h00, 0, 0,  7'h00, 0, 1);

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      exp_t e;
      rst = vecs[i].rst; upd_en = vecs[i].upd; res = vecs[i].res;
      carry = vecs[i].c; ovf = vecs[i].o; ld_en = vecs[i].ld;
      ld_val = vecs[i].ldv; push = vecs[i].psh; pop = vecs[i].pp;
      e.name = vecs[i].name; e.tgt = edge_cnt + 1; e.psr = vecs[i].e_psr;
      e.dep = vecs[i].e_dep; e.err = vecs[i].e_err;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
    end
    rst = 1'b0; upd_en = 1'b0; ld_en = 1'b0; push = 1'b0; pop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
